// File: rtl/uart_tx_pkg.sv
// Shared types and mux-select codes for the UART TX path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [2:0] MUX_IDLE  = 3'b000;
    localparam logic [2:0] MUX_START = 3'b001;
    localparam logic [2:0] MUX_DATA  = 3'b010;
    localparam logic [2:0] MUX_PAR   = 3'b011;
    localparam logic [2:0] MUX_STOP  = 3'b100;

    function automatic logic [2:0] mux_of(input tx_state_e s);
        logic [2:0] m;
        m = MUX_IDLE;
        case (s)
            START:   m = MUX_START;
            DATA:    m = MUX_DATA;
            PARITY:  m = MUX_PAR;
            STOP:    m = MUX_STOP;
            default: m = MUX_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_serializer.sv
// Shift register and bit counter; the LSB is the bit on the line.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_i,
    input  logic                  shift_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_data_o,
    output logic                  done_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign done_o     = (cnt_q == CW'(DATA_WIDTH - 1));
    assign ser_data_o = shift_q[0];

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            // explicit wrap so non-power-of-two widths also return to 0
            cnt_d   = done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data LSB-first, parity, stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [2:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    tx_state_e  state_q, state_d;
    logic [2:0] mux_sel_q;
    logic       busy_q;
    logic       accept;
    logic       done;

    assign accept = ((state_q == IDLE) || (state_q == STOP)) && Data_Valid;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (accept),
        .shift_en_i (state_q == DATA),
        .data_i     (P_DATA),
        .ser_data_o (ser_data),
        .done_o     (done)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
        end
    end

    assign par_bit = par_bit_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
    assign par_bit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = START;
            START: state_d = DATA;
            DATA: begin
                if (done) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from the state being entered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            mux_sel_q <= MUX_IDLE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_of(state_d);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign mux_sel = mux_sel_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [2:0] mux_sel;
    logic       ser_data;
    logic       par_bit;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        Data_Valid = 1'b1;
        P_DATA = 8'h3C;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mux_sel !== 3'b000 || busy !== 1'b0 ||
                par_bit !== 1'b0 || ser_data !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d] got mux=%b busy=%b par=%b ser=%b want 000/0/0/0",
                         i, mux_sel, busy, par_bit, ser_data);
            end
        end
        Data_Valid = 1'b0;
        RST = 1'b1;
        tick();
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got mux=%b busy=%b want 000/0", mux_sel, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        int bcnt;
        d = 8'hA5;
        bcnt = 0;
        P_DATA = d;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        P_DATA = 8'h00;
        if (busy === 1'b1) bcnt++;
        checks++;
        if (mux_sel !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_start got mux=%b busy=%b want 001/1", mux_sel, busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy === 1'b1) bcnt++;
            checks++;
            if (mux_sel !== 3'b010 || ser_data !== d[i]) begin
                errors++;
                $display("FAIL basic_bit[%0d] got mux=%b ser=%b want 010/%b",
                         i, mux_sel, ser_data, d[i]);
            end
        end
        tick();
        if (busy === 1'b1) bcnt++;
        checks++;
        if (mux_sel !== 3'b100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_stop got mux=%b busy=%b want 100/1", mux_sel, busy);
        end
        tick();
        if (busy === 1'b1) bcnt++;
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got mux=%b busy=%b want 000/0", mux_sel, busy);
        end
        checks++;
        if (bcnt != 10) begin
            errors++;
            $display("FAIL basic_busy_len got %0d want 10", bcnt);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic [1:0] par_tbl;
        logic       exp_par;
        d = 8'h07;
        // 0x07 has three ones: even -> 1, odd -> 0
        par_tbl = 2'b01;
        for (int t = 0; t < 2; t++) begin
`ifdef UART_TX_PARITY_EN
            exp_par = par_tbl[t];
`else
            exp_par = 1'b0;
`endif
            P_DATA = d;
            PAR_EN = 1'b1;
            PAR_TYP = t[0];
            Data_Valid = 1'b1;
            tick();
            Data_Valid = 1'b0;
            PAR_EN = 1'b0;
            PAR_TYP = ~PAR_TYP;
            P_DATA = 8'hFF;
            checks++;
            if (mux_sel !== 3'b001 || par_bit !== exp_par) begin
                errors++;
                $display("FAIL par%0d_start got mux=%b par=%b want 001/%b",
                         t, mux_sel, par_bit, exp_par);
            end
            for (int i = 0; i < 8; i++) begin
                tick();
                checks++;
                if (mux_sel !== 3'b010 || ser_data !== d[i]) begin
                    errors++;
                    $display("FAIL par%0d_bit[%0d] got mux=%b ser=%b want 010/%b",
                             t, i, mux_sel, ser_data, d[i]);
                end
            end
`ifdef UART_TX_PARITY_EN
            tick();
            checks++;
            if (mux_sel !== 3'b011 || par_bit !== exp_par || busy !== 1'b1) begin
                errors++;
                $display("FAIL par%0d_parcycle got mux=%b par=%b busy=%b want 011/%b/1",
                         t, mux_sel, par_bit, busy, exp_par);
            end
`endif
            tick();
            checks++;
            if (mux_sel !== 3'b100 || par_bit !== exp_par) begin
                errors++;
                $display("FAIL par%0d_stop got mux=%b par=%b want 100/%b",
                         t, mux_sel, par_bit, exp_par);
            end
            tick();
            checks++;
            if (mux_sel !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL par%0d_idle got mux=%b busy=%b want 000/0",
                         t, mux_sel, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        logic [7:0] d2;
        d1 = 8'h55;
        d2 = 8'h33;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        P_DATA = d1;
        Data_Valid = 1'b1;
        tick();
        checks++;
        if (mux_sel !== 3'b001) begin
            errors++;
            $display("FAIL b2b_start1 got mux=%b want 001", mux_sel);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (mux_sel !== 3'b010 || ser_data !== d1[i]) begin
                errors++;
                $display("FAIL b2b_f1_bit[%0d] got mux=%b ser=%b want 010/%b",
                         i, mux_sel, ser_data, d1[i]);
            end
        end
        tick();
        P_DATA = d2;
        checks++;
        if (mux_sel !== 3'b100) begin
            errors++;
            $display("FAIL b2b_stop1 got mux=%b want 100", mux_sel);
        end
        tick();
        Data_Valid = 1'b0;
        checks++;
        if (mux_sel !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start2 got mux=%b busy=%b want 001/1", mux_sel, busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (mux_sel !== 3'b010 || ser_data !== d2[i]) begin
                errors++;
                $display("FAIL b2b_f2_bit[%0d] got mux=%b ser=%b want 010/%b",
                         i, mux_sel, ser_data, d2[i]);
            end
        end
        tick();
        checks++;
        if (mux_sel !== 3'b100) begin
            errors++;
            $display("FAIL b2b_stop2 got mux=%b want 100", mux_sel);
        end
        tick();
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got mux=%b busy=%b want 000/0", mux_sel, busy);
        end
    endtask

    task automatic test_ignore_busy();
        P_DATA = 8'h00;
        PAR_EN = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) begin
                P_DATA = 8'hFF;
                Data_Valid = 1'b1;
            end else begin
                Data_Valid = 1'b0;
            end
            checks++;
            if (mux_sel !== 3'b010 || ser_data !== 1'b0) begin
                errors++;
                $display("FAIL ign_bit[%0d] got mux=%b ser=%b want 010/0",
                         i, mux_sel, ser_data);
            end
        end
        tick();
        checks++;
        if (mux_sel !== 3'b100) begin
            errors++;
            $display("FAIL ign_stop got mux=%b want 100", mux_sel);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mux_sel !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ign_idle[%0d] got mux=%b busy=%b want 000/0",
                         i, mux_sel, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        P_DATA = 8'hF0;
        PAR_EN = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (mux_sel !== 3'b010 || ser_data !== 1'b1) begin
            errors++;
            $display("FAIL rmid_bit4 got mux=%b ser=%b want 010/1", mux_sel, ser_data);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0 ||
            ser_data !== 1'b0 || par_bit !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got mux=%b busy=%b ser=%b par=%b want 000/0/0/0",
                     mux_sel, busy, ser_data, par_bit);
        end
        tick();
        RST = 1'b1;
        tick();
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after got mux=%b busy=%b want 000/0", mux_sel, busy);
        end
        d = 8'h81;
        P_DATA = d;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        checks++;
        if (mux_sel !== 3'b001) begin
            errors++;
            $display("FAIL rmid_start got mux=%b want 001", mux_sel);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (mux_sel !== 3'b010 || ser_data !== d[i]) begin
                errors++;
                $display("FAIL rmid_bit[%0d] got mux=%b ser=%b want 010/%b",
                         i, mux_sel, ser_data, d[i]);
            end
        end
        tick();
        checks++;
        if (mux_sel !== 3'b100) begin
            errors++;
            $display("FAIL rmid_stop got mux=%b want 100", mux_sel);
        end
        tick();
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_idle got mux=%b busy=%b want 000/0", mux_sel, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
